// File: rtl/si5340_reg_seq.sv
// Si5340 register-access sequencer: turns one page:register read/write request
// into the byte-controller command sequence, caching the device page register.
module si5340_reg_seq #(
    parameter int         DATA_WIDTH     = 8,
    parameter logic [6:0] DEV_ADDR       = 7'h74,
    parameter logic [7:0] PAGE_REG       = 8'h01,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    // Request channel: a request transfers on the rising edge where
    // req_valid_i && req_ready_o; the request fields must be stable while
    // req_valid_i is high, and ready stays low until the response has gone out.
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rw_i,
    input  logic [15:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  read_o,
    output logic                  write_o,
    output logic                  ack_in_o,
    output logic [DATA_WIDTH-1:0] din_o,
    input  logic [DATA_WIDTH-1:0] dout_i,
    input  logic                  cmd_ack_i,
    output logic [3:0]            dbg_state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PG_DEV = 4'd1,
        S_PG_REG = 4'd2,
        S_PG_DAT = 4'd3,
        S_DEV_W  = 4'd4,
        S_REG    = 4'd5,
        S_WDATA  = 4'd6,
        S_RS_DEV = 4'd7,
        S_RDATA  = 4'd8,
        S_RSP    = 4'd9
    } state_t;

    typedef struct packed {
        logic                  start;
        logic                  stop;
        logic                  read;
        logic                  write;
        logic                  ack_in;
        logic [DATA_WIDTH-1:0] din;
    } cmd_t;

    state_t                state_q;
    logic                  pending_q;
    logic [TW-1:0]         timer_q;
    cmd_t                  cmd_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rw_q;
    logic [15:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pg_valid_q;
    logic [7:0]            pg_q;
    state_t                first_state;

    // A cold or different page must be selected before the access itself.
    assign first_state = (!pg_valid_q || (pg_q != req_addr_i[15:8])) ? S_PG_DEV : S_DEV_W;

    function automatic cmd_t cmd_for(input state_t s, input logic [15:0] a,
                                     input logic [DATA_WIDTH-1:0] wd);
        cmd_t c;
        c = '0;
        case (s)
            S_PG_DEV: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = DATA_WIDTH'({DEV_ADDR, 1'b0});
            end
            S_PG_REG: begin
                c.write = 1'b1;
                c.din   = DATA_WIDTH'(PAGE_REG);
            end
            S_PG_DAT: begin
                c.write = 1'b1;
                c.stop  = 1'b1;
                c.din   = DATA_WIDTH'(a[15:8]);
            end
            S_DEV_W: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = DATA_WIDTH'({DEV_ADDR, 1'b0});
            end
            S_REG: begin
                c.write = 1'b1;
                c.din   = DATA_WIDTH'(a[7:0]);
            end
            S_WDATA: begin
                c.write = 1'b1;
                c.stop  = 1'b1;
                c.din   = wd;
            end
            S_RS_DEV: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = DATA_WIDTH'({DEV_ADDR, 1'b1});
            end
            S_RDATA: begin
                // ack_in=1 NACKs the single read byte so the slave releases SDA.
                c.read   = 1'b1;
                c.stop   = 1'b1;
                c.ack_in = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(input state_t s, input logic rw);
        state_t n;
        n = S_IDLE;
        case (s)
            S_PG_DEV: n = S_PG_REG;
            S_PG_REG: n = S_PG_DAT;
            S_PG_DAT: n = S_DEV_W;
            S_DEV_W:  n = S_REG;
            S_REG:    n = rw ? S_RS_DEV : S_WDATA;
            S_RS_DEV: n = S_RDATA;
            S_WDATA:  n = S_RSP;
            S_RDATA:  n = S_RSP;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            timer_q     <= '0;
            cmd_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pg_valid_q  <= 1'b0;
            pg_q        <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && ready_q) begin
                        rw_q      <= req_rw_i;
                        addr_q    <= req_addr_i;
                        wdata_q   <= req_wdata_i;
                        ready_q   <= 1'b0;
                        state_q   <= first_state;
                        cmd_q     <= cmd_for(first_state, req_addr_i, req_wdata_i);
                        pending_q <= 1'b1;
                        timer_q   <= '0;
                    end
                end
                S_RSP: begin
                    ready_q   <= 1'b1;
                    rsp_err_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    if (pending_q) begin
                        if (cmd_ack_i) begin
                            // Dropping the command here creates the mandatory idle gap.
                            cmd_q     <= '0;
                            pending_q <= 1'b0;
                            state_q   <= next_state(state_q, rw_q);
                            if (state_q == S_PG_DAT) begin
                                pg_valid_q <= 1'b1;
                                pg_q       <= addr_q[15:8];
                            end
                            if (state_q == S_RDATA) begin
                                rsp_rdata_q <= dout_i;
                            end
                            if ((state_q == S_WDATA) || (state_q == S_RDATA)) begin
                                rsp_valid_q <= 1'b1;
                            end
                        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            // The device may be left mid-transaction, so the page is unknown.
                            cmd_q       <= '0;
                            pending_q   <= 1'b0;
                            pg_valid_q  <= 1'b0;
                            state_q     <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end else begin
                        cmd_q     <= cmd_for(state_q, addr_q, wdata_q);
                        pending_q <= 1'b1;
                        timer_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign start_o     = cmd_q.start;
    assign stop_o      = cmd_q.stop;
    assign read_o      = cmd_q.read;
    assign write_o     = cmd_q.write;
    assign ack_in_o    = cmd_q.ack_in;
    assign din_o       = cmd_q.din;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_si5340_reg_seq.sv
// Bench for si5340_reg_seq: byte-controller responder, page-aware reference model
// and an expected-command scoreboard, driven by directed then random requests.
module tb_si5340_reg_seq;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        arstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_rw_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [7:0]  req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [7:0]  rsp_rdata_o;
    logic        rsp_err_o;
    logic        start_o, stop_o, read_o, write_o, ack_in_o;
    logic [7:0]  din_o;
    logic [7:0]  dout_i = '0;
    logic        cmd_ack_i;
    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [3:0]  dbg_state_o;

    assign cmd_ack_i = resp_ack | spur_ack;

    si5340_reg_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .arstn_i(arstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .start_o(start_o), .stop_o(stop_o), .read_o(read_o), .write_o(write_o),
        .ack_in_o(ack_in_o), .din_o(din_o), .dout_i(dout_i), .cmd_ack_i(cmd_ack_i),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] cur_cmd();
        return {start_o, stop_o, read_o, write_o, ack_in_o, din_o};
    endfunction

    function automatic logic [12:0] mk(input bit s, input bit p, input bit r, input bit w,
                                       input bit a, input logic [7:0] d);
        return {s, p, r, w, a, d};
    endfunction

    // Scoreboard and observation state.
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];
    int          obs_cyc[$];
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    logic [8:0]  rsp_val = '0;
    int          acc_cnt = 0;
    int          drop_cyc = 0;

    // Byte-controller responder configuration.
    int   lat = 4;
    bit   noack = 1'b0;
    bit   spur_gap_en = 1'b0;
    int   phase = 0;
    int   cnt = 0;
    bit   ack_out = 1'b0;
    bit   spur_clear = 1'b0;
    logic [12:0] cur = '0;

    always @(negedge clk) begin
        if (!arstn_i) begin
            phase = 0; resp_ack = 1'b0; ack_out = 1'b0; spur_clear = 1'b0;
        end else if (ack_out) begin
            resp_ack = 1'b0;
            ack_out  = 1'b0;
            check("gap_idle", 32'(cur_cmd()), 32'(0));
            if (spur_gap_en) begin
                resp_ack = 1'b1;
                spur_clear = 1'b1;
            end
        end else begin
            if (spur_clear) begin
                resp_ack = 1'b0;
                spur_clear = 1'b0;
            end
            if (phase == 1) begin
                if (cur_cmd() == 13'd0) begin
                    drop_cyc = cyc;
                    phase = 0;
                end else begin
                    check("cmd_stable", 32'(cur_cmd()), 32'(cur));
                    if (!noack) begin
                        if (cnt == 0) begin
                            resp_ack = 1'b1; ack_out = 1'b1; phase = 0;
                        end else begin
                            cnt--;
                        end
                    end
                end
            end else if (cur_cmd() != 13'd0) begin
                cur = cur_cmd();
                obs_q.push_back(cur);
                obs_cyc.push_back(cyc);
                if (noack) phase = 1;
                else if (lat == 0) begin
                    resp_ack = 1'b1; ack_out = 1'b1;
                end else begin
                    cnt = lat - 1; phase = 1;
                end
            end
        end
        if (rsp_valid_o) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_val = {rsp_err_o, rsp_rdata_o};
        end
    end

    always @(posedge clk) if (req_valid_i && req_ready_o) acc_cnt++;

    // Reference model: Si5340 page-select protocol at transaction level.
    bit         rp_valid = 1'b0;
    logic [7:0] rp = '0;
    logic [7:0] last_rdata = '0;

    task automatic model_req(input bit rw, input logic [15:0] a, input logic [7:0] wd);
        if (!rp_valid || rp != a[15:8]) begin
            exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
            exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h01));
            exp_q.push_back(mk(0, 1, 0, 1, 0, a[15:8]));
            rp_valid = 1'b1;
            rp = a[15:8];
        end
        exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
        exp_q.push_back(mk(0, 0, 0, 1, 0, a[7:0]));
        if (rw) begin
            exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hE9));
            exp_q.push_back(mk(0, 1, 1, 0, 1, 8'h00));
        end else begin
            exp_q.push_back(mk(0, 1, 0, 1, 0, wd));
        end
    endtask

    task automatic do_req(input string tag, input bit rw, input logic [15:0] a,
                          input logic [7:0] wd, input int lat_i, input logic [7:0] rb,
                          input bit to_mode);
        int acc_c;
        int n;
        int ne;
        logic [8:0] exp_rsp;
        lat = lat_i;
        noack = to_mode;
        dout_i = rb;
        exp_q.delete();
        model_req(rw, a, wd);
        if (to_mode) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
            rp_valid = 1'b0;
            exp_rsp = 9'h100;
            last_rdata = 8'h00;
        end else if (rw) begin
            exp_rsp = {1'b0, rb};
            last_rdata = rb;
        end else begin
            exp_rsp = {1'b0, last_rdata};
        end
        ne = exp_q.size();
        obs_q.delete(); obs_cyc.delete();
        rsp_cnt = 0; acc_cnt = 0;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(req_ready_o), 32'(1));
        req_valid_i = 1'b1; req_rw_i = rw; req_addr_i = a; req_wdata_i = wd;
        acc_c = cyc;
        @(negedge clk);
        check({tag, "_ready_low"}, 32'(req_ready_o), 32'(0));
        check({tag, "_first_cmd_now"}, 32'(cur_cmd() != 13'd0), 32'(1));
        n = 0;
        while (!rsp_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        req_valid_i = 1'b0;
        #1;
        check({tag, "_rsp_count"}, 32'(rsp_cnt), 32'(1));
        check({tag, "_rsp_val"}, 32'(rsp_val), 32'(exp_rsp));
        check({tag, "_accepts"}, 32'(acc_cnt), 32'(1));
        check({tag, "_cmd_count"}, 32'(obs_q.size()), 32'(ne));
        for (int i = 0; i < ne && i < obs_q.size(); i++) begin
            check($sformatf("%s_cmd%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        if (obs_cyc.size() > 0) begin
            check({tag, "_first_cycle"}, 32'(obs_cyc[0]), 32'(acc_c + 1));
            for (int i = 1; i < obs_cyc.size(); i++) begin
                check($sformatf("%s_spacing%0d", tag, i), 32'(obs_cyc[i] - obs_cyc[i-1]),
                      32'(lat + 2));
            end
            if (to_mode) begin
                check({tag, "_drop_cycle"}, 32'(drop_cyc), 32'(obs_cyc[0] + TO));
                check({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(obs_cyc[0] + TO));
            end else begin
                check({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(obs_cyc[obs_cyc.size()-1] + lat + 1));
            end
        end
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(req_ready_o), 32'(1));
        check({tag, "_rsp_pulse"}, 32'(rsp_valid_o), 32'(0));
        noack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, 32'(cur_cmd()), 32'(0));
        check({tag, "_ready"}, 32'(req_ready_o), 32'(1));
        check({tag, "_rsp"}, 32'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 32'(0));
        check({tag, "_state"}, 32'(dbg_state_o), 32'(0));
    endtask

    initial begin
        int n;
        // Reset
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        arstn_i = 1'b1;

        do_req("wr_0b24", 1'b0, 16'h0B24, 8'h5A, 4, 8'h00, 1'b0);

        // Spurious acks while idle must not start anything.
        obs_q.delete(); rsp_cnt = 0; acc_cnt = 0;
        @(negedge clk); spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        check("idle_spur_cmds", 32'(obs_q.size()), 32'(0));
        check("idle_spur_rsp", 32'(rsp_cnt), 32'(0));
        check("idle_spur_ready", 32'(req_ready_o), 32'(1));

        spur_gap_en = 1'b1;
        do_req("wr_0b25", 1'b0, 16'h0B25, 8'h11, 4, 8'h00, 1'b0);
        spur_gap_en = 1'b0;

        do_req("rd_0c10", 1'b1, 16'h0C10, 8'h00, 4, 8'hA7, 1'b0);
        do_req("timeout", 1'b0, 16'h0C11, 8'h33, 4, 8'h00, 1'b1);
        do_req("rd_0c12", 1'b1, 16'h0C12, 8'h00, 2, 8'h3C, 1'b0);
        do_req("wr_0b30", 1'b0, 16'h0B30, 8'h9E, 1, 8'h00, 1'b0);

        // Reset while the REG command is outstanding.
        lat = 4; noack = 1'b0;
        obs_q.delete(); obs_cyc.delete();
        @(negedge clk);
        req_valid_i = 1'b1; req_rw_i = 1'b0; req_addr_i = 16'h0B27; req_wdata_i = 8'h44;
        n = 0;
        while (obs_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_reg", 32'(obs_q.size()), 32'(2));
        if (obs_q.size() >= 2) check("abort_reg_cmd", 32'(obs_q[1]), 32'(mk(0, 0, 0, 1, 0, 8'h27)));
        arstn_i = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check_reset_outputs("midreset_now");
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_held");
        arstn_i = 1'b1;
        rp_valid = 1'b0;
        last_rdata = 8'h00;
        do_req("wr_0b26", 1'b0, 16'h0B26, 8'h77, 3, 8'h00, 1'b0);

        // Random traffic against the reference model.
        for (int k = 0; k < 12; k++) begin
            logic [15:0] ra;
            ra = {8'($urandom_range(11, 13)), 8'($urandom_range(0, 255))};
            do_req($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), ra,
                   8'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                   8'($urandom_range(0, 255)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
